grid_serializer: RTL and testbench

GRID_SERIALIZER -- requirements
Module: grid_serializer

---
 rtl/grid_serializer.sv | 155 +++++++++++++++
 tb/tb_grid_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_serializer.sv
// grid_serializer
// Captures a 64-cell (8x8) grid on each accepted generation tick and offers it
// to a sink one 8-bit row at a time over a valid/ready handshake. It also
// reports per-frame statistics (live-cell count, extinction) and a running
// frame counter.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   _rst       : asynchronous active-low reset
//   grid_in    : 64-bit cell array, bit r*8+c = cell[r][c]
//   gen_tick   : one-cycle pulse, grid_in holds a new generation
//   out_data   : row being offered, bit c = cell[out_row][c]
//   out_row    : index of the row on out_data
//   out_valid  : out_data/out_row valid
//   out_ready  : sink accepts the offered row
//   frame_end  : high while row 7 is offered
//   busy       : high while a frame is in progress
//   gen_count  : number of frames captured (wraps modulo 2^CNT_W)
//   live_count : popcount of the captured frame
//   extinct    : captured frame has no live cells
//   overrun    : sticky, a generation arrived mid-frame and was dropped
module grid_serializer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [63:0]      grid_in,
  input  logic             gen_tick,
  output logic [7:0]       out_data,
  output logic [2:0]       out_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_end,
  output logic             busy,
  output logic [CNT_W-1:0] gen_count,
  output logic [6:0]       live_count,
  output logic             extinct,
  output logic             overrun
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r;
  logic [63:0]        snap_r;
  logic [7:0]         out_data_r;
  logic [2:0]         out_row_r;
  logic               out_valid_r;
  logic               frame_end_r;
  logic               busy_r;
  logic [CNT_W-1:0]   gen_count_r;
  logic [6:0]         live_count_r;
  logic               extinct_r;
  logic               overrun_r;

  logic               last_xfer_s;
  logic               capture_s;
  logic [2:0]         next_row_s;
  logic [7:0]         next_data_s;

  // Number of live cells in a 64-cell grid.
  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  // Capture decision and the row that follows the one currently offered.
  always_comb begin
    last_xfer_s = 1'b0;
    capture_s   = 1'b0;
    next_row_s  = out_row_r + 3'd1;
    next_data_s = snap_r[{next_row_s, 3'b000} +: 8];
    if (state_r == SEND) begin
      last_xfer_s = out_ready && (out_row_r == 3'd7);
      // Back-to-back frame: a tick coinciding with the final transfer is taken.
      capture_s   = gen_tick && last_xfer_s;
    end else begin
      capture_s   = gen_tick;
    end
  end

  // Serializer FSM with registered outputs and frame statistics.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_r      <= IDLE;
      snap_r       <= 64'd0;
      out_data_r   <= 8'd0;
      out_row_r    <= 3'd0;
      out_valid_r  <= 1'b0;
      frame_end_r  <= 1'b0;
      busy_r       <= 1'b0;
      gen_count_r  <= '0;
      live_count_r <= 7'd0;
      extinct_r    <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (capture_s) begin
        state_r      <= SEND;
        snap_r       <= grid_in;
        out_data_r   <= grid_in[7:0];
        out_row_r    <= 3'd0;
        out_valid_r  <= 1'b1;
        frame_end_r  <= 1'b0;
        busy_r       <= 1'b1;
        gen_count_r  <= gen_count_r + CNT_W'(1);
        live_count_r <= popcount64(grid_in);
        extinct_r    <= (grid_in == 64'd0);
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          SEND: begin
            // A tick that cannot be taken is dropped and remembered.
            if (gen_tick) begin
              overrun_r <= 1'b1;
            end
            if (out_ready) begin
              if (out_row_r == 3'd7) begin
                state_r     <= IDLE;
                out_valid_r <= 1'b0;
                busy_r      <= 1'b0;
                frame_end_r <= 1'b0;
              end else begin
                out_row_r   <= next_row_s;
                out_data_r  <= next_data_s;
                frame_end_r <= (next_row_s == 3'd7);
              end
            end
          end
          default: begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_end_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_row    = out_row_r;
  assign out_valid  = out_valid_r;
  assign frame_end  = frame_end_r;
  assign busy       = busy_r;
  assign gen_count  = gen_count_r;
  assign live_count = live_count_r;
  assign extinct    = extinct_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_grid_serializer.sv
// Directed self-checking bench for grid_serializer. A second instance with a
// 4-bit generation counter shares all inputs to exercise counter wrap.
module tb_grid_serializer;

  logic        clk;
  logic        rst_n;
  logic [63:0] grid_in;
  logic        gen_tick;
  logic        out_ready;

  logic [7:0]  out_data;
  logic [2:0]  out_row;
  logic        out_valid;
  logic        frame_end;
  logic        busy;
  logic [15:0] gen_count;
  logic [6:0]  live_count;
  logic        extinct;
  logic        overrun;

  logic [7:0]  out_data_b;
  logic [2:0]  out_row_b;
  logic        out_valid_b;
  logic        frame_end_b;
  logic        busy_b;
  logic [3:0]  gen_count_b;
  logic [6:0]  live_count_b;
  logic        extinct_b;
  logic        overrun_b;

  int vectors;
  int miscompares;
  int gc;

  grid_serializer #(.CNT_W(16)) dut (
    .clk(clk), ._rst(rst_n), .grid_in(grid_in), .gen_tick(gen_tick),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .frame_end(frame_end), .busy(busy),
    .gen_count(gen_count), .live_count(live_count), .extinct(extinct),
    .overrun(overrun)
  );

  grid_serializer #(.CNT_W(4)) dut_w4 (
    .clk(clk), ._rst(rst_n), .grid_in(grid_in), .gen_tick(gen_tick),
    .out_data(out_data_b), .out_row(out_row_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .frame_end(frame_end_b), .busy(busy_b),
    .gen_count(gen_count_b), .live_count(live_count_b), .extinct(extinct_b),
    .overrun(overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a grid with a one-cycle tick; the DUT must be able to take it.
  task automatic capture(input logic [63:0] g);
    grid_in  = g;
    gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    gc++;
  endtask

  // Walk a whole frame under continuous ready, checking every row.
  task automatic drain_check(input logic [63:0] g, input string tag);
    logic [7:0] row_exp;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      row_exp = g[r*8 +: 8];
      check({tag, "_row"},  {61'd0, out_row}, r);
      check({tag, "_data"}, {56'd0, out_data}, {56'd0, row_exp});
      check({tag, "_fend"}, {63'd0, frame_end}, {63'd0, (r == 7)});
      step();
    end
    check({tag, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_idle_busy"},  {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, out_data, out_row, out_valid, frame_end, busy, gen_count,
            live_count, extinct, overrun};
  endfunction

  initial begin
    logic [63:0] ga;
    logic [63:0] gb;
    vectors     = 0;
    miscompares = 0;
    gc          = 0;
    rst_n       = 1'b0;
    grid_in     = 64'd0;
    gen_tick    = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    step();
    step();
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_valid", {63'd0, out_valid}, 64'd0);

    // Basic capture
    out_ready = 1'b1;
    capture(64'h0000_0018_0000_00FF);
    check("t1_valid",  {63'd0, out_valid}, 64'd1);
    check("t1_busy",   {63'd0, busy}, 64'd1);
    check("t1_live",   {57'd0, live_count}, 64'd10);
    check("t1_extinct", {63'd0, extinct}, 64'd0);
    check("t1_gen",    {48'd0, gen_count}, 64'd1);
    drain_check(64'h0000_0018_0000_00FF, "t1");
    // grid_in changes while idle must not disturb anything
    grid_in = 64'hDEAD_BEEF_1234_5678;
    step();
    check("t1_idle_data", {56'd0, out_data}, 64'h00);
    check("t1_idle_live", {57'd0, live_count}, 64'd10);
    check("t1_idle_gen",  {48'd0, gen_count}, 64'd1);

    // Backpressure on row 3
    ga = 64'h8877_6655_4433_2211;
    capture(ga);
    for (int r = 0; r < 3; r++) begin
      check("t2_row", {61'd0, out_row}, r);
      step();
    end
    out_ready = 1'b0;
    grid_in   = 64'h0;
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_row",  {61'd0, out_row}, 64'd3);
      check("t2_hold_data", {56'd0, out_data}, 64'h44);
      step();
    end
    out_ready = 1'b1;
    for (int r = 3; r < 8; r++) begin
      check("t2_row",  {61'd0, out_row}, r);
      check("t2_data", {56'd0, out_data}, {56'd0, ga[r*8 +: 8]});
      step();
    end
    check("t2_idle", {63'd0, out_valid}, 64'd0);

    // Overrun at row 2, then back-to-back tick on the row-7 transfer
    ga = 64'h0102_0408_1020_4080;
    gb = 64'hF0F0_F0F0_F0F0_F0F0;
    capture(ga);
    step();
    step();
    check("t3_row2", {61'd0, out_row}, 64'd2);
    check("t3_ovr_pre", {63'd0, overrun}, 64'd0);
    grid_in  = gb;
    gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    check("t3_ovr", {63'd0, overrun}, 64'd1);
    check("t3_row3", {61'd0, out_row}, 64'd3);
    check("t3_data3", {56'd0, out_data}, 64'h10);
    check("t3_gen_hold", {48'd0, gen_count}, gc);
    check("t3_live_hold", {57'd0, live_count}, 64'd8);
    for (int r = 3; r < 7; r++) begin
      check("t3_data", {56'd0, out_data}, {56'd0, ga[r*8 +: 8]});
      step();
    end
    check("t3_row7", {61'd0, out_row}, 64'd7);
    check("t3_fend7", {63'd0, frame_end}, 64'd1);
    capture(gb);
    check("t3_b2b_row",  {61'd0, out_row}, 64'd0);
    check("t3_b2b_data", {56'd0, out_data}, 64'hF0);
    check("t3_b2b_busy", {63'd0, busy}, 64'd1);
    check("t3_b2b_gen",  {48'd0, gen_count}, gc);
    check("t3_b2b_live", {57'd0, live_count}, 64'd32);
    check("t3_ovr_sticky", {63'd0, overrun}, 64'd1);
    drain_check(gb, "t3b");

    // Extinct and full grids
    capture(64'd0);
    check("t4_extinct", {63'd0, extinct}, 64'd1);
    check("t4_live0",   {57'd0, live_count}, 64'd0);
    drain_check(64'd0, "t4a");
    capture({64{1'b1}});
    check("t4_live64",  {57'd0, live_count}, 64'd64);
    check("t4_full_ext", {63'd0, extinct}, 64'd0);
    drain_check({64{1'b1}}, "t4b");

    // Counter wrap on the 4-bit instance: 17 captures in total
    while (gc < 17) begin
      capture(64'h1 << gc);
      for (int r = 0; r < 8; r++) step();
    end
    check("t5_gen16", {48'd0, gen_count}, 64'd17);
    check("t5_gen4",  {60'd0, gen_count_b}, 64'd1);

    // Asynchronous reset at row 5
    ga = 64'hA5A5_5A5A_C3C3_3C3C;
    capture(ga);
    for (int r = 0; r < 5; r++) step();
    check("t6_row5", {61'd0, out_row}, 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_outs", all_outs(), 64'd0);
    check("t6_async_gen4", {60'd0, gen_count_b}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_valid", {63'd0, out_valid}, 64'd0);
    end
    // A tick on the very first edge after release is taken
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    grid_in  = 64'h0000_0000_0000_0003;
    gen_tick = 1'b1;
    step();
    gen_tick = 1'b0;
    check("t7_valid", {63'd0, out_valid}, 64'd1);
    check("t7_data",  {56'd0, out_data}, 64'h03);
    check("t7_gen",   {48'd0, gen_count}, 64'd1);
    check("t7_live",  {57'd0, live_count}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
